// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared types and constants for the instruction-fetch
//               controller: default reset PC and memory depth, the fetch
//               mode enum, the FIFO entry layout and the PC legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    localparam logic [31:0] c_reset_pc = 32'h0000_3000;
    localparam int unsigned c_im_words = 1024;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_SQUASH = 2'd1,
        MODE_HALT   = 2'd2
    } mode_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } fetch_entry_t;

    // Word aligned and inside [base, base + 4*words - 4]. The offset is
    // shifted before comparing so the range end cannot overflow 32 bits.
    function automatic logic pc_legal(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input logic [31:0] words);
        logic [31:0] offset;
        offset = pc - base;
        return (pc[1:0] == 2'b00) && (pc >= base) && ((offset >> 2) < words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Two-entry synchronous FIFO of fetched instructions with
//               flush, simultaneous push/pop and occupancy output.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               flush           - empties the FIFO (wins over push/pop)
//               push/push_entry - write one entry
//               pop             - drop the head entry
//               head            - current head entry (zero after reset)
//               count           - occupancy, 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = pop && (r_count != 2'd0);
    // A push into a full FIFO is only accepted when the head leaves at the
    // same edge; the freed slot is the one the write pointer points at.
    assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch controller. Owns the fetch PC, issues word
//               reads over a req/ack handshake, buffers up to two fetched
//               instructions, applies redirects, squashes stale responses
//               and turns illegal fetch addresses into fault markers.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               stall                       - IF/ID holds, head not consumed
//               redirect_valid, redirect_pc - taken branch/jump/eret target
//               im_req, im_addr             - read request to memory
//               im_ack, im_rdata            - memory accept and data
//               if_valid, if_pc, if_instr,
//               if_exc                      - FIFO head towards IF/ID
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter int unsigned IM_WORDS = c_im_words
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_exc
);

    localparam logic [31:0] c_words = 32'(IM_WORDS);

    mode_t       r_mode;
    logic [31:0] r_pc;
    logic        r_req;
    logic [31:0] r_addr;

    fetch_entry_t w_head;
    fetch_entry_t w_push_entry;
    logic [1:0]   w_count;
    logic [1:0]   w_count_next;
    logic         w_push;
    logic         w_pop;
    logic         w_ack;
    logic         w_hold;
    logic         w_pc_ok;
    logic         w_issue;
    mode_t        w_mode_next;
    logic [31:0]  w_pc_next;

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .count      (w_count)
    );

    assign if_valid = (w_count != 2'd0);
    assign if_pc    = w_head.pc;
    assign if_instr = w_head.instr;
    assign if_exc   = w_head.exc;

    assign im_req  = r_req;
    assign im_addr = r_addr;

    // The request flag doubles as the outstanding flag: a request is in
    // flight exactly while im_req is high.
    assign w_ack   = r_req && im_ack;
    assign w_hold  = r_req && !im_ack;
    assign w_pop   = if_valid && !stall;
    assign w_pc_ok = pc_legal(r_pc, RESET_PC, c_words);

    always_comb begin
        w_push       = 1'b0;
        w_push_entry = '0;
        w_mode_next  = r_mode;
        w_pc_next    = r_pc;

        if (redirect_valid) begin
            // Any ack in this cycle is dropped; a still-pending request must
            // be drained before the new target can be fetched.
            w_pc_next   = redirect_pc;
            w_mode_next = w_hold ? MODE_SQUASH : MODE_RUN;
        end else begin
            case (r_mode)
                MODE_RUN: begin
                    if (w_ack) begin
                        w_push       = 1'b1;
                        w_push_entry = '{pc: r_addr, instr: im_rdata, exc: 1'b0};
                        w_pc_next    = r_pc + 32'd4;
                    end else if (!r_req && !w_pc_ok && (w_count != 2'd2)) begin
                        w_push       = 1'b1;
                        w_push_entry = '{pc: r_pc, instr: 32'h0, exc: 1'b1};
                        w_mode_next  = MODE_HALT;
                    end
                end
                MODE_SQUASH: begin
                    if (w_ack) begin
                        w_mode_next = MODE_RUN;
                    end
                end
                default: begin
                end
            endcase
        end

        if (redirect_valid) begin
            w_count_next = 2'd0;
        end else begin
            w_count_next = w_count + {1'b0, w_push} - {1'b0, w_pop};
        end

        // Deciding the next request from next-state values keeps im_req high
        // back-to-back when every request is acked in its own cycle.
        w_issue = (w_mode_next == MODE_RUN)
                  && pc_legal(w_pc_next, RESET_PC, c_words)
                  && (w_count_next != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_RUN;
            r_pc   <= RESET_PC;
            r_req  <= 1'b0;
            r_addr <= RESET_PC;
        end else begin
            r_mode <= w_mode_next;
            r_pc   <= w_pc_next;
            if (w_hold) begin
                r_req <= 1'b1;
            end else if (w_issue) begin
                r_req  <= 1'b1;
                r_addr <= w_pc_next;
            end else begin
                r_req <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. A memory responder with
//               programmable latency answers requests; a scoreboard holds
//               the instruction stream expected after each reset/redirect
//               and a monitor compares every consumed FIFO head against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] c_base  = 32'h0000_3000;
    localparam logic [31:0] c_limit = 32'h0000_3FFC;  // last legal word

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack = 1'b0;
    logic [31:0] im_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_exc;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] data_key = 32'h0;
    int          mem_lat = 0;
    int          hs_cnt = 0;
    int          consumed = 0;
    bit          halted = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } exp_t;
    exp_t exp_q[$];

    fetch_ctrl #(.RESET_PC(32'h0000_3000), .IM_WORDS(1024)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_req         (im_req),
        .im_addr        (im_addr),
        .im_ack         (im_ack),
        .im_rdata       (im_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_exc         (if_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input logic [31:0] p);
        return (p[1:0] == 2'b00) && (p >= c_base) && (p <= c_limit);
    endfunction

    // Whatever the timing, the heads seen after a reset/redirect are a
    // prefix of: target, target+4, ... up to the first illegal PC, which
    // appears once as a fault marker and ends the stream.
    task automatic expect_stream(input logic [31:0] start);
        logic [31:0] p;
        p = start;
        exp_q.delete();
        halted = 1'b0;
        for (int i = 0; i < 128; i++) begin
            if (!legal(p)) begin
                exp_q.push_back('{p, 32'h0, 1'b1});
                break;
            end
            exp_q.push_back('{p, p ^ data_key, 1'b0});
            p = p + 32'd4;
        end
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        expect_stream(t);
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset(input logic [31:0] key, input logic stall_v, input int lat);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        stall          = stall_v;
        mem_lat        = lat;
        tick();
        tick();
        data_key = key;
        rst_n    = 1'b1;
        expect_stream(c_base);
    endtask

    task automatic wait_req(input logic [31:0] addr, input int limit, input string name);
        int n;
        n = 0;
        while (!(im_req && (im_addr == addr)) && (n < limit)) begin
            tick();
            n++;
        end
        chk(name, {32'b0, im_req, im_addr}, {32'b0, 1'b1, addr});
    endtask

    task automatic fault_test(input logic [31:0] t);
        redirect(t);
        chk("fault_n1_idle", {63'b0, if_valid, im_req}, 65'b0);
        tick();
        chk("fault_valid", {64'b0, if_valid}, 65'd1);
        chk("fault_entry", {if_exc, if_pc, if_instr}, {1'b1, t, 32'h0});
        repeat (5) tick();
        chk("fault_no_req", {64'b0, im_req}, 65'b0);
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] base;
        base = c_base + 32'(4 * $urandom_range(0, 1023));
        case ($urandom_range(0, 7))
            0, 1, 2, 3: return base;
            4:          return 32'h0000_4000 - 32'(4 * $urandom_range(1, 6));
            5:          return base | 32'($urandom_range(1, 3));
            6:          return 32'h0000_4000 + 32'(4 * $urandom_range(0, 255));
            default:    return 32'h0000_2000 + 32'(4 * $urandom_range(0, 1023));
        endcase
    endfunction

    // Memory responder: acks after mem_lat waiting cycles, data = addr ^ key,
    // and checks that a waiting request keeps im_req/im_addr stable.
    initial begin : memory
        int          cnt;
        bit          pend;
        logic [31:0] paddr;
        cnt   = 0;
        pend  = 1'b0;
        paddr = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                im_ack = 1'b0;
                cnt    = 0;
                pend   = 1'b0;
            end else begin
                if (pend) begin
                    chk("req_hold", {32'b0, im_req, im_addr}, {32'b0, 1'b1, paddr});
                end
                if (im_req) begin
                    if (cnt >= mem_lat) begin
                        im_ack   = 1'b1;
                        im_rdata = im_addr ^ data_key;
                        cnt      = 0;
                        pend     = 1'b0;
                        hs_cnt++;
                    end else begin
                        im_ack = 1'b0;
                        cnt++;
                        pend   = 1'b1;
                        paddr  = im_addr;
                    end
                end else begin
                    im_ack = 1'b0;
                    cnt    = 0;
                    pend   = 1'b0;
                end
            end
        end
    end

    // Monitor: a head is consumed at an edge with if_valid && !stall; in a
    // redirect cycle the FIFO is flushed instead, so nothing is compared.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !redirect_valid) begin
                if (halted) begin
                    chk("halt_no_req", {64'b0, im_req}, 65'b0);
                end
                if (if_valid && !stall) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_head: actual=%h required=none",
                                 {if_pc, if_instr, if_exc});
                    end else begin
                        e = exp_q.pop_front();
                        chk("head", {if_pc, if_instr, if_exc}, {e.pc, e.instr, e.exc});
                        consumed++;
                        if (e.exc) begin
                            halted = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : stimulus
        int h0;
        int c0;
        int since;

        // Reset values
        tick();
        chk("rst_im_req",   65'(im_req),   65'd0);
        chk("rst_im_addr",  65'(im_addr),  65'(c_base));
        chk("rst_if_valid", 65'(if_valid), 65'd0);
        chk("rst_if_pc",    65'(if_pc),    65'd0);
        chk("rst_if_instr", 65'(if_instr), 65'd0);
        chk("rst_if_exc",   65'(if_exc),   65'd0);

        // Streaming, one instruction per cycle
        rst_n = 1'b1;
        expect_stream(c_base);
        tick();
        chk("first_req", {32'b0, im_req, im_addr}, {32'b0, 1'b1, c_base});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stream", {if_valid, if_pc, if_instr},
                {1'b1, c_base + 32'(4 * i), c_base + 32'(4 * i)});
        end

        // Stall fills the FIFO
        do_reset(32'h0, 1'b1, 0);
        h0 = hs_cnt;
        repeat (6) tick();
        chk("stall_handshakes", 65'(hs_cnt - h0), 65'd2);
        chk("stall_no_req", 65'(im_req), 65'd0);
        chk("stall_head", {if_valid, if_pc, if_instr}, {1'b1, c_base, c_base});
        stall = 1'b0;
        repeat (5) tick();

        // Redirect while a request is outstanding
        do_reset(32'h0, 1'b0, 3);
        wait_req(32'h0000_3004, 20, "wait_3004");
        tick();
        redirect(32'h0000_3100);
        chk("squash_hold", {32'b0, im_req, im_addr}, {32'b0, 1'b1, 32'h0000_3004});
        wait_req(32'h0000_3100, 10, "req_after_squash");
        h0 = 0;
        while (!if_valid && (h0 < 20)) begin
            tick();
            h0++;
        end
        chk("first_after_squash", {if_valid, if_pc, if_instr},
            {1'b1, 32'h0000_3100, 32'h0000_3100});

        // Redirect coinciding with an ack
        mem_lat = 0;
        repeat (4) tick();
        chk("pre_redirect_req", 65'(im_req), 65'd1);
        redirect(32'h0000_3200);
        chk("redir_n1", {31'b0, if_valid, im_req, im_addr},
            {31'b0, 1'b0, 1'b1, 32'h0000_3200});
        tick();
        chk("redir_n2", {if_valid, if_pc, if_instr}, {1'b1, 32'h0000_3200, 32'h0000_3200});
        repeat (3) tick();

        // Address faults and recovery
        fault_test(32'h0000_3102);
        redirect(32'h0000_3000);
        repeat (6) tick();
        fault_test(32'h0000_4000);
        redirect(32'h0000_3000);
        repeat (4) tick();

        // Reset in the middle of a request
        mem_lat = 3;
        tick();
        chk("pre_reset_req", 65'(im_req), 65'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {63'b0, if_valid, im_req}, 65'b0);
        tick();
        mem_lat = 0;
        rst_n   = 1'b1;
        expect_stream(c_base);
        tick();
        chk("refetch", {32'b0, im_req, im_addr}, {32'b0, 1'b1, c_base});
        repeat (4) tick();

        // Randomized traffic against the stream model
        do_reset($urandom | 32'h1, 1'b0, 0);
        c0    = consumed;
        since = 0;
        for (int c = 0; c < 2000; c++) begin
            stall   = ($urandom_range(0, 9) < 3);
            mem_lat = $urandom_range(0, 3);
            if (($urandom_range(0, 24) == 0) || (since >= 90)) begin
                since          = 0;
                redirect_valid = 1'b1;
                redirect_pc    = pick_target();
                expect_stream(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
                since++;
            end
            tick();
        end
        redirect_valid = 1'b0;
        stall          = 1'b0;
        repeat (5) tick();
        chk("random_progress", 65'((consumed - c0) > 100), 65'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller between the pipeline IF stage and the instruction memory.
- Owns the fetch PC and issues word reads over a req/ack handshake.
- Buffers up to two fetched instructions in a 2-entry FIFO so a stall does not lose data.
- Applies branch/jump redirects, squashes stale responses, and flags misaligned or out-of-range fetch addresses.
- Sits between the hazard/branch logic and the instruction memory, and feeds the IF/ID register.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC loaded at reset
- IM_WORDS, 1024, instruction memory depth in words; valid range is RESET_PC .. RESET_PC+4*IM_WORDS-4

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit holds IF/ID; FIFO head not consumed
- redirect_valid  in  1  branch/jump/eret taken this cycle
- redirect_pc  in  32  new fetch target
- im_req  out  1  read request to instruction memory
- im_addr  out  32  byte address of request; word index = im_addr[11:2]
- im_ack  in  1  memory accepted request; im_rdata valid this cycle
- im_rdata  in  32  instruction word
- if_valid  out  1  FIFO head valid
- if_pc  out  32  PC of FIFO head
- if_instr  out  32  instruction of FIFO head
- if_exc  out  1  FIFO head is an address-fault marker (instr = 0)

## Operation
- State: fetch PC `pc`, 2-entry FIFO {pc, instr, exc}, one outstanding-request flag, mode ∈ {RUN, SQUASH, HALT}.
- Issue rule (RUN only): im_req rises when no request is outstanding, occupancy < 2, and `pc` is legal. im_addr = `pc`.
- Handshake: once asserted, im_req and im_addr stay constant until im_ack. im_ack may arrive in the same cycle as im_req. At most one request is outstanding.
- Ack in RUN: enqueue {pc, im_rdata, 0}; pc ← pc+4, wrapping modulo 2^32.
- Consume: at every edge where if_valid && !stall, dequeue the head. Enqueue and dequeue may coincide at the same edge; occupancy is then unchanged.
- Legality: a PC is legal when pc[1:0]==0 and it lies in range. When `pc` is illegal in RUN, the block issues no request, enqueues {pc, 0, 1} once FIFO space exists, and enters HALT.
- HALT: no requests and no further enqueues; stays until a redirect.
- Redirect (priority over stall and over ack), at the edge where it is sampled:
  - FIFO flushed.
  - pc ← redirect_pc.
  - If a request is outstanding and im_ack is not asserted that cycle → SQUASH.
  - Otherwise → RUN. An ack in the redirect cycle is discarded.
- SQUASH: im_req stays held with the old address. On im_ack the data is discarded → RUN.
- Redirect during SQUASH: pc is updated, mode stays SQUASH.

## Timing
- Reset values:
  - im_req=0, im_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=0, if_exc=0.
  - pc=RESET_PC, mode RUN, FIFO empty, nothing outstanding.
- Reset asserted mid-request drops im_req immediately; the in-flight response is ignored.
- im_req is a registered output. The first request is issued in the first cycle after rst_n deasserts.
- Enqueue latency: an ack at edge N makes if_valid=1 from cycle N+1.
- Throughput: one instruction per cycle when im_ack is asserted in the same cycle as im_req and stall=0.
- Redirect at edge N:
  - if_valid=0 in cycle N+1.
  - The new address is on im_addr in cycle N+1 unless in SQUASH.
  - The first new-target instruction is visible in N+2 with a same-cycle ack.
- FIFO full (2) with stall=1: no request is issued; if_* are held stable.

## Structure
- Shared package: RESET_PC constant, the IM_WORDS default, the mode enum {RUN, SQUASH, HALT}, and the FIFO entry struct {pc, instr, exc}.
- One sub-module: `fetch_fifo`, a 2-entry synchronous FIFO with flush, simultaneous push/pop, and occupancy output.
- All control logic lives in fetch_ctrl.

## Test plan
- **Reset and streaming:** rst_n low, then high; memory acks same-cycle with data = addr. Expect if_pc = 0x3000, 0x3004, 0x3008 on consecutive cycles, with if_instr matching.
- **Stall fills FIFO:** stall=1 for 5 cycles. Expect at most 2 requests (0x3000, 0x3004), then im_req=0 and head held at 0x3000. After stall=0, expect 0x3000, 0x3004, 0x3008 in order.
- **Redirect with outstanding request:** memory delays ack 3 cycles on 0x3004; redirect to 0x3100 one cycle after req. Expect im_addr to stay 0x3004 until ack, that data discarded, then im_req at 0x3100 and the first if_pc = 0x3100.
- **Redirect coinciding with ack:** redirect to 0x3200 in the ack cycle. Expect the acked word never appears and the next if_pc = 0x3200.
- **Address faults:**
  - Redirect to 0x3102: expect if_valid=1, if_exc=1, if_pc=0x3102, if_instr=0, then no further im_req.
  - A subsequent redirect to 0x3000 resumes normal fetch.
  - Redirect to 0x4000 (out of range) produces the same fault response.
- **Mid-operation reset:** rst_n low while im_req=1. Expect im_req=0 and if_valid=0 immediately; refetch from 0x3000 after release.
